// File: rtl/pll_fb_lock_detect.sv
// Frequency-window PLL lock detector: counts retimed feedback edges per WIN_LEN reference cycles.
// Results appear one cycle after each window end. There is no backpressure. Optional sticky loss-of-lock is enabled by PLL_LOCK_STICKY_LOSS_EN.
module pll_fb_lock_detect #(
  parameter int WIN_LEN      = 256,
  parameter int EXP_EDGES    = 64,
  parameter int TOL          = 1,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 9
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             en,
  input  logic             fb_q,
  input  logic             clr_loss,
  output logic             retime_kln,
  output logic             locked,
  output logic             win_done,
  output logic [CNT_W-1:0] win_count,
  output logic             win_err,
  output logic             loss_sticky
);

  localparam int WC_W = $clog2(WIN_LEN);
  localparam int GC_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_EDGES);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t                  state, state_nx;
  logic                    fb_q_d;
  logic [WC_W-1:0]         wc;
  logic [CNT_W-1:0]        ec;
  logic [GC_W-1:0]         gc, gc_nx;
  logic                    fb_edge;
  logic                    counting;
  logic                    win_end;
  logic                    good;
  logic [CNT_W-1:0]        final_cnt;
  logic signed [CNT_W:0]   diff;

  assign fb_edge   = fb_q & ~fb_q_d;
  assign counting  = (state != IDLE);
  assign win_end   = counting && en && (wc == WC_W'(WIN_LEN - 1));
  // An edge on the last cycle still belongs to the window being closed.
  assign final_cnt = (fb_edge && (ec != CNT_MAX)) ? ec + 1'b1 : ec;
  assign diff      = $signed({1'b0, final_cnt}) - EXP_S;
  assign good      = (diff <= TOL_S) && (diff >= -TOL_S);

  always_comb begin
    state_nx = state;
    gc_nx    = gc;
    if (!en) begin
      state_nx = IDLE;
      gc_nx    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = ACQUIRE;
          gc_nx    = '0;
        end
        ACQUIRE: begin
          if (win_end) begin
            if (good) begin
              gc_nx = gc + 1'b1;
              if (gc == GC_W'(LOCK_WINDOWS - 1)) state_nx = LOCKED;
            end else begin
              gc_nx = '0;
            end
          end
        end
        LOCKED: begin
          if (win_end && !good) begin
            state_nx = ACQUIRE;
            gc_nx    = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      gc         <= '0;
      wc         <= '0;
      ec         <= '0;
      fb_q_d     <= 1'b0;
      retime_kln <= 1'b0;
      locked     <= 1'b0;
      win_done   <= 1'b0;
      win_count  <= '0;
      win_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      gc         <= gc_nx;
      retime_kln <= en;
      fb_q_d     <= en & fb_q;
      locked     <= (state_nx == LOCKED);
      win_done   <= win_end;
      // wc wraps naturally because WIN_LEN is a power of two.
      if (!counting || !en) begin
        wc <= '0;
        ec <= '0;
      end else begin
        wc <= wc + 1'b1;
        ec <= win_end ? '0 : final_cnt;
      end
      if (win_end) begin
        win_count <= final_cnt;
        win_err   <= !good;
      end
    end
  end

`ifdef PLL_LOCK_STICKY_LOSS_EN
  logic sticky_set;
  assign sticky_set = (state == LOCKED) && win_end && !good;

  always_ff @(posedge CP or posedge RST) begin
    if (RST)             loss_sticky <= 1'b0;
    else if (sticky_set) loss_sticky <= 1'b1;
    else if (clr_loss)   loss_sticky <= 1'b0;
  end
`else
  logic unused_clr_loss;
  assign unused_clr_loss = clr_loss;
  assign loss_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_fb_lock_detect.sv
// Randomized scoreboard bench for pll_fb_lock_detect: a window-level model predicts each published result.
module tb_pll_fb_lock_detect;

  localparam int WIN_LEN = 256;
  localparam int EXP     = 64;
  localparam int TOL     = 1;
  localparam int LOCKW   = 4;
  localparam int CNT_W   = 9;

  logic             CP = 1'b0;
  logic             RST, en, fb_q, clr_loss;
  logic             retime_kln, locked, win_done, win_err, loss_sticky;
  logic [CNT_W-1:0] win_count;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             lck;
    logic             stk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  bit               prev_fb;
  int               gph;
  int               gc_m;
  bit               locked_m, sticky_m;
  logic [CNT_W-1:0] last_cnt;
  bit               last_err;

  pll_fb_lock_detect dut (
    .CP(CP), .RST(RST), .en(en), .fb_q(fb_q), .clr_loss(clr_loss),
    .retime_kln(retime_kln), .locked(locked), .win_done(win_done),
    .win_count(win_count), .win_err(win_err), .loss_sticky(loss_sticky)
  );

  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Window-level reference: decide good/bad, lock progress and sticky loss from the edge total.
  task automatic model_end(input int count, input bit clr);
    exp_t e;
    bit   bad, was;
    bad = (count > EXP + TOL) || (count < EXP - TOL);
    was = locked_m;
    if (!bad) begin
      gc_m++;
      if (gc_m >= LOCKW) locked_m = 1'b1;
    end else begin
      gc_m     = 0;
      locked_m = 1'b0;
    end
`ifdef PLL_LOCK_STICKY_LOSS_EN
    if (clr) sticky_m = 1'b0;
    if (was && bad) sticky_m = 1'b1;
`else
    sticky_m = 1'b0;
`endif
    e.cnt    = (count > 511) ? 9'd511 : count[CNT_W-1:0];
    e.err    = bad;
    e.lck    = locked_m;
    e.stk    = sticky_m;
    last_cnt = e.cnt;
    last_err = bad;
    sb.push_back(e);
  endtask

  // Called in a drive slot while the DUT is idle; the next edge starts acquisition.
  task automatic enable_det();
    en       = 1'b1;
    fb_q     = 1'b0;
    clr_loss = 1'b0;
    prev_fb  = 1'b0;
    gph      = 0;
    gc_m     = 0;
    locked_m = 1'b0;
  endtask

  // mode 0: square wave period a; 1: a one-cycle pulses every b cycles from offset c;
  // 2: constant a; 3: random bits.
  task automatic run_window(input int mode, input int a, input int b, input int c,
                            input int clr_pos, input int drop_pos, input int rst_pos);
    int cnt = 0;
    bit clr = 1'b0;
    bit v;
    for (int i = 0; i < WIN_LEN; i++) begin
      @(posedge CP); #1;
      case (mode)
        0:       v = ((gph % a) < a / 2);
        1:       v = (i >= c) && (((i - c) % b) == 0) && (((i - c) / b) < a);
        2:       v = a[0];
        default: v = 1'($urandom_range(1, 0));
      endcase
      gph++;
      fb_q     = v;
      clr_loss = (i == clr_pos);
      if (i == clr_pos) clr = 1'b1;
      if (v && !prev_fb) cnt++;
      prev_fb = v;
      if (i == drop_pos) begin
        en = 1'b0;
        return;
      end
      if (i == rst_pos) begin
        #2 RST = 1'b1;
        #1;
        chk("rst_async_kln",      retime_kln,  0);
        chk("rst_async_locked",   locked,      0);
        chk("rst_async_win_done", win_done,    0);
        chk("rst_async_count",    win_count,   0);
        chk("rst_async_err",      win_err,     0);
        chk("rst_async_sticky",   loss_sticky, 0);
        #2 RST = 1'b0;
        fb_q     = 1'b0;
        clr_loss = 1'b0;
        gc_m     = 0;
        locked_m = 1'b0;
        sticky_m = 1'b0;
        last_cnt = '0;
        last_err = 1'b0;
        return;
      end
    end
    model_end(cnt, clr);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CP); #1;
      clr_loss = 1'b0;
    end
  endtask

  // Monitor: every published result must match the oldest pending expectation.
  initial begin
    forever begin
      @(posedge CP); #1;
      if (win_done === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_win_done: got win_done=1 expected none (count=%0d) at %0t",
                   win_count, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("win_count",   win_count,   mon_e.cnt);
          chk("win_err",     win_err,     mon_e.err);
          chk("locked",      locked,      mon_e.lck);
          chk("loss_sticky", loss_sticky, mon_e.stk);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", sb.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; en = 1'b0; fb_q = 1'b0; clr_loss = 1'b0;
    prev_fb = 1'b0; gph = 0; gc_m = 0; locked_m = 1'b0; sticky_m = 1'b0;
    last_cnt = '0; last_err = 1'b0;
    #12;
    chk("reset_kln",      retime_kln,  0);
    chk("reset_locked",   locked,      0);
    chk("reset_win_done", win_done,    0);
    chk("reset_count",    win_count,   0);
    chk("reset_err",      win_err,     0);
    chk("reset_sticky",   loss_sticky, 0);
    #10 RST = 1'b0;
    @(posedge CP); #1;
    chk("idle_kln", retime_kln, 0);
    enable_det();

    for (int w = 0; w < 4; w++) run_window(0, 4, 0, 0, -1, -1, -1);
    run_window(0, 5, 0, 0, -1, -1, -1);
    for (int w = 0; w < 4; w++) run_window(0, 4, 0, 0, -1, -1, -1);

    run_window(1, 63, 3, 1, -1, -1, -1);
    run_window(1, 65, 3, 1, -1, -1, -1);
    run_window(1, 66, 3, 1, -1, -1, -1);
    run_window(1, 64, 4, 3, 100, -1, -1);
    for (int w = 0; w < 3; w++) run_window(0, 4, 0, 0, -1, -1, -1);
    run_window(2, 1, 0, 0, 255, -1, -1);
    run_window(2, 1, 0, 0, -1, -1, -1);
    run_window(0, 4, 0, 0, 20, -1, -1);
    for (int w = 0; w < 3; w++) run_window(3, 0, 0, 0, -1, -1, -1);

    run_window(0, 4, 0, 0, -1, 255, -1);
    idle_cycles(4);
    chk("drop_kln",      retime_kln, 0);
    chk("drop_locked",   locked,     0);
    chk("drop_hold_cnt", win_count,  last_cnt);
    chk("drop_hold_err", win_err,    last_err);
    chk("drop_pending",  sb.size(),  0);
    enable_det();
    for (int w = 0; w < 2; w++) run_window(0, 4, 0, 0, -1, -1, -1);

    run_window(0, 4, 0, 0, -1, -1, 100);
    @(posedge CP); #1;
    chk("rst_release_kln", retime_kln, 1);
    en = 1'b0;
    @(posedge CP); #1;
    enable_det();
    for (int w = 0; w < 4; w++) run_window(0, 4, 0, 0, -1, -1, -1);

    idle_cycles(4);
    chk("final_locked", locked,    1);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
